// File: rtl/i2c_receiver_slave.sv
// Write-only I2C responder: oversamples SCL/SDA, ACKs {DEV_ADDR,W}, a register byte
// and one data byte, then presents the register/data pair with a one-cycle strobe.
module i2c_receiver_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h1A
) (
  input  logic       CLK_50MHZ,
  input  logic       RESET_N,
  input  logic       I2C_SCL,
  input  logic       I2C_SDA_IN,
  output logic       I2C_SDA_OUT,
  output logic       I2C_SDA_EN,
  output logic [7:0] REG_ADDR,
  output logic [7:0] DATA,
  output logic       DATA_VALID,
  output logic       BUSY,
  output logic       ERROR
);

  // state     | meaning
  // IDLE      | bus free, waiting for START
  // DEV_BYTE  | shifting in device address + R/W
  // DEV_ACK   | 9th clock of the address byte, driving ACK
  // REG_BYTE  | shifting in register address
  // REG_ACK   | 9th clock of the register byte, driving ACK
  // DATA_BYTE | shifting in data byte
  // DATA_ACK  | 9th clock of the data byte, driving ACK
  // IGNORE    | not addressed or transfer done; NACK until START/STOP
  typedef enum logic [2:0] {
    IDLE, DEV_BYTE, DEV_ACK, REG_BYTE, REG_ACK, DATA_BYTE, DATA_ACK, IGNORE
  } state_t;

  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;
  logic scl_rise, scl_fall, start_p, stop_p;

  state_t     state_q, state_d;
  logic [2:0] count_q, count_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] hold_q, hold_d;
  logic       ack_seen_q, ack_seen_d;
  logic       sda_en_d, valid_d, error_d;
  logic [7:0] reg_addr_d, data_d;
  logic [7:0] byte_full;
  logic       in_byte, in_ack;

  // Synchronizers idle high so reset does not fabricate bus edges.
  always_ff @(posedge CLK_50MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      scl_s1   <= 1'b1;
      scl_s2   <= 1'b1;
      scl_d    <= 1'b1;
      sda_s1   <= 1'b1;
      sda_s2   <= 1'b1;
      sda_d    <= 1'b1;
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      start_p  <= 1'b0;
      stop_p   <= 1'b0;
    end else begin
      scl_s1   <= I2C_SCL;
      scl_s2   <= scl_s1;
      scl_d    <= scl_s2;
      sda_s1   <= I2C_SDA_IN;
      sda_s2   <= sda_s1;
      sda_d    <= sda_s2;
      scl_rise <= scl_s2 & ~scl_d;
      scl_fall <= ~scl_s2 & scl_d;
      start_p  <= scl_s2 & scl_d & sda_d & ~sda_s2;
      stop_p   <= scl_s2 & scl_d & ~sda_d & sda_s2;
    end
  end

  // Strobes are one stage behind the delayed copies, so sda_d lines up with scl_rise.
  assign byte_full = {shift_q[6:0], sda_d};
  assign in_byte   = (state_q == DEV_BYTE) || (state_q == REG_BYTE) || (state_q == DATA_BYTE);
  assign in_ack    = (state_q == DEV_ACK) || (state_q == REG_ACK) || (state_q == DATA_ACK);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    ack_seen_d = ack_seen_q;
    sda_en_d   = I2C_SDA_EN;
    reg_addr_d = REG_ADDR;
    data_d     = DATA;
    valid_d    = 1'b0;
    error_d    = 1'b0;

    if (stop_p || start_p) begin
      error_d    = (in_byte && (count_q != 3'd0)) || in_ack;
      state_d    = stop_p ? IDLE : DEV_BYTE;
      count_d    = 3'd0;
      ack_seen_d = 1'b0;
      sda_en_d   = 1'b0;
    end else begin
      case (state_q)
        DEV_BYTE, REG_BYTE, DATA_BYTE: begin
          if (scl_rise) begin
            shift_d    = byte_full;
            count_d    = count_q + 3'd1;
            ack_seen_d = 1'b0;
            if (count_q == 3'd7) begin
              case (state_q)
                DEV_BYTE: state_d = (byte_full == {DEV_ADDR, 1'b0}) ? DEV_ACK : IGNORE;
                REG_BYTE: begin
                  hold_d  = byte_full;
                  state_d = REG_ACK;
                end
                default: begin
                  reg_addr_d = hold_q;
                  data_d     = byte_full;
                  valid_d    = 1'b1;
                  state_d    = DATA_ACK;
                end
              endcase
            end
          end
        end
        DEV_ACK, REG_ACK, DATA_ACK: begin
          if (scl_fall) begin
            if (!ack_seen_q) begin
              ack_seen_d = 1'b1;
              sda_en_d   = 1'b1;
            end else begin
              ack_seen_d = 1'b0;
              sda_en_d   = 1'b0;
              case (state_q)
                DEV_ACK: state_d = REG_BYTE;
                REG_ACK: state_d = DATA_BYTE;
                default: state_d = IGNORE;
              endcase
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK_50MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      count_q    <= 3'd0;
      shift_q    <= 8'h00;
      hold_q     <= 8'h00;
      ack_seen_q <= 1'b0;
      I2C_SDA_EN <= 1'b0;
      REG_ADDR   <= 8'h00;
      DATA       <= 8'h00;
      DATA_VALID <= 1'b0;
      BUSY       <= 1'b0;
      ERROR      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      ack_seen_q <= ack_seen_d;
      I2C_SDA_EN <= sda_en_d;
      REG_ADDR   <= reg_addr_d;
      DATA       <= data_d;
      DATA_VALID <= valid_d;
      BUSY       <= (state_d != IDLE);
      ERROR      <= error_d;
    end
  end

  assign I2C_SDA_OUT = 1'b0;

endmodule

// File: tb/tb_i2c_receiver_slave.sv
// Bench for i2c_receiver_slave: bit-banged bus stimulus, a transaction-level model
// delayed by the fixed pipeline latency, and literal end-of-transaction expectations.
module tb_i2c_receiver_slave;

  localparam int H   = 8;
  localparam int HQ  = 4;
  localparam int LAT = 4;
  localparam logic [6:0] DEV = 7'h1A;

  logic       clk, rst_n, scl, sda;
  logic       sda_out, sda_en, data_valid, busy, error;
  logic [7:0] reg_addr, data;

  i2c_receiver_slave #(.DEV_ADDR(DEV)) dut (
    .CLK_50MHZ(clk), .RESET_N(rst_n), .I2C_SCL(scl), .I2C_SDA_IN(sda),
    .I2C_SDA_OUT(sda_out), .I2C_SDA_EN(sda_en), .REG_ADDR(reg_addr), .DATA(data),
    .DATA_VALID(data_valid), .BUSY(busy), .ERROR(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 25) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: phase 0 idle, 1 address byte, 2 register byte, 3 data byte, 4 ignoring.
  int         m_phase = 0;
  int         m_nb = 0;
  int         m_acc = 0;
  int         m_falls = 0;
  bit         m_inack = 0;
  logic [7:0] m_hold = 8'h00;
  logic       m_en = 0, m_busy = 0, m_valid = 0, m_error = 0;
  logic [7:0] m_reg = 8'h00, m_data = 8'h00;

  task automatic model_rise(input logic b);
    if (m_phase >= 1 && m_phase <= 3 && !m_inack) begin
      m_acc = m_acc * 2 + int'(b);
      m_nb++;
      if (m_nb == 8) begin
        m_nb = 0;
        if (m_phase == 1) begin
          if (m_acc == int'(DEV) * 2) m_inack = 1;
          else m_phase = 4;
        end else if (m_phase == 2) begin
          m_hold  = m_acc[7:0];
          m_inack = 1;
        end else begin
          m_reg   = m_hold;
          m_data  = m_acc[7:0];
          m_valid = 1;
          m_inack = 1;
        end
        m_acc   = 0;
        m_falls = 0;
      end
    end
  endtask

  task automatic model_fall();
    if (m_inack) begin
      m_falls++;
      if (m_falls == 1) m_en = 1;
      else begin
        m_en    = 0;
        m_inack = 0;
        m_phase = (m_phase == 3) ? 4 : m_phase + 1;
      end
    end
  endtask

  task automatic model_cond(input bit is_stop);
    if (m_inack || (m_phase >= 1 && m_phase <= 3 && m_nb != 0)) m_error = 1;
    m_phase = is_stop ? 0 : 1;
    m_busy  = !is_stop;
    m_nb    = 0;
    m_acc   = 0;
    m_inack = 0;
    m_en    = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      m_valid = 0;
      m_error = 0;
    end
  endtask

  task automatic bus_start();
    sda = 0; model_cond(0); tick(H);
    scl = 0; model_fall();  tick(HQ);
  endtask

  task automatic bus_stop();
    sda = 0; tick(HQ);
    scl = 1; model_rise(1'b0); tick(H);
    sda = 1; model_cond(1); tick(H);
  endtask

  task automatic clk_bit(input logic b);
    sda = b; tick(HQ);
    scl = 1; model_rise(b); tick(H);
    scl = 0; model_fall();  tick(HQ);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) clk_bit(b[i]);
    clk_bit(1'b1);
  endtask

  task automatic write3(input logic [7:0] a, input logic [7:0] r, input logic [7:0] d);
    bus_start();
    send_byte(a);
    send_byte(r);
    send_byte(d);
    bus_stop();
  endtask

  // Per-cycle compare against the model, delayed by the synchronizer/strobe/output latency.
  bit         chk_en = 0;
  int         h_cnt = 0;
  logic       h_en[5], h_busy[5], h_valid[5], h_err[5];
  logic [7:0] h_reg[5], h_data[5];

  always @(negedge clk) begin
    if (!chk_en) h_cnt = 0;
    else begin
      for (int i = 4; i > 0; i--) begin
        h_en[i] = h_en[i-1]; h_busy[i] = h_busy[i-1]; h_valid[i] = h_valid[i-1];
        h_err[i] = h_err[i-1]; h_reg[i] = h_reg[i-1]; h_data[i] = h_data[i-1];
      end
      h_en[0] = m_en; h_busy[0] = m_busy; h_valid[0] = m_valid;
      h_err[0] = m_error; h_reg[0] = m_reg; h_data[0] = m_data;
      if (h_cnt < LAT) h_cnt++;
      else begin
        check("sda_en", sda_en, h_en[LAT]);
        check("sda_out", sda_out, 0);
        check("busy", busy, h_busy[LAT]);
        check("data_valid", data_valid, h_valid[LAT]);
        check("error", error, h_err[LAT]);
        check("reg_addr", reg_addr, h_reg[LAT]);
        check("data", data, h_data[LAT]);
      end
    end
  end

  int   n_valid = 0, n_err = 0, n_en_rise = 0;
  logic en_prev = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid) n_valid++;
      if (error) n_err++;
      if (sda_en && !en_prev) n_en_rise++;
    end
    en_prev = sda_en;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; scl = 1; sda = 1;
    tick(3);
    check("rst_busy", busy, 0);
    check("rst_sda_en", sda_en, 0);
    check("rst_reg_addr", reg_addr, 8'h00);
    check("rst_data", data, 8'h00);
    check("rst_valid_error", {data_valid, error}, 2'b00);
    rst_n = 1;
    chk_en = 1;
    tick(10);

    // Addressed write
    write3(8'h34, 8'h0E, 8'h4A);
    tick(10);
    check("t1_reg_addr", reg_addr, 8'h0E);
    check("t1_data", data, 8'h4A);
    check("t1_valid_count", n_valid, 1);
    check("t1_ack_count", n_en_rise, 3);
    check("t1_busy_after_stop", busy, 0);

    // Wrong address
    bus_start();
    send_byte(8'h36);
    send_byte(8'h0E);
    tick(6);
    check("t2_busy_before_stop", busy, 1);
    bus_stop();
    tick(10);
    check("t2_ack_count", n_en_rise, 3);
    check("t2_valid_count", n_valid, 1);
    check("t2_data", data, 8'h4A);

    // Read request
    bus_start();
    send_byte(8'h35);
    bus_stop();
    tick(10);
    check("t3_ack_count", n_en_rise, 3);
    check("t3_error_count", n_err, 0);

    // Extra data byte after a full write
    bus_start();
    send_byte(8'h34);
    send_byte(8'h0E);
    send_byte(8'h4A);
    send_byte(8'h55);
    bus_stop();
    tick(10);
    check("t4_ack_count", n_en_rise, 6);
    check("t4_valid_count", n_valid, 2);
    check("t4_data", data, 8'h4A);

    // Truncated register byte, then a clean write
    bus_start();
    send_byte(8'h34);
    for (int i = 0; i < 4; i++) clk_bit(1'b0);
    bus_stop();
    tick(10);
    check("t5_error_count", n_err, 1);
    check("t5_valid_count", n_valid, 2);
    check("t5_busy", busy, 0);
    write3(8'h34, 8'h01, 8'hFF);
    tick(10);
    check("t5_reg_addr", reg_addr, 8'h01);
    check("t5_data", data, 8'hFF);
    check("t5_valid_count2", n_valid, 3);
    check("t5_error_count2", n_err, 1);

    // Asynchronous reset during the register ACK clock
    bus_start();
    send_byte(8'h34);
    for (int i = 7; i >= 0; i--) clk_bit(i == 3 || i == 2 || i == 1);
    tick(2);
    sda = 1; scl = 1;
    tick(3);
    #3;
    check("t6_en_before_reset", sda_en, 1);
    chk_en = 0;
    rst_n = 0;
    #1;
    check("t6_en_in_reset", sda_en, 0);
    check("t6_busy_in_reset", busy, 0);
    check("t6_reg_addr_in_reset", reg_addr, 8'h00);
    check("t6_data_in_reset", data, 8'h00);
    m_phase = 0; m_nb = 0; m_acc = 0; m_inack = 0; m_falls = 0;
    m_en = 0; m_busy = 0; m_reg = 8'h00; m_data = 8'h00; m_hold = 8'h00;
    tick(2);
    rst_n = 1;
    chk_en = 1;
    scl = 0; model_fall(); tick(HQ);
    bus_stop();
    tick(10);
    check("t6_busy_after", busy, 0);
    check("t6_data_after", data, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
